// File: rtl/lock_controller.sv
// Six-digit keypad lock: code entry and judging, timed unlock, password change,
// and a timed lockout after three consecutive wrong codes.
module lock_controller #(
    parameter logic [23:0] DEFAULT_PWD  = 24'h123456,
    parameter int unsigned UNLOCK_SECS  = 10,
    parameter int unsigned LOCKOUT_SECS = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       tick,
    output logic       unlocked,
    output logic       alarm,
    output logic       judge,
    output logic       pass_ok,
    output logic [1:0] err_count,
    output logic [2:0] digit_cnt,
    output logic [5:0] remain
);

    localparam int unsigned PWD_W = 24;
    localparam int unsigned REM_W = 6;
    localparam int unsigned CNT_W = 3;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        JUDGE   = 3'd1,
        OPEN    = 3'd2,
        SETPWD  = 3'd3,
        LOCKOUT = 3'd4
    } state_t;

    state_t             state, state_n;
    logic [PWD_W-1:0]   entry, entry_n;
    logic [PWD_W-1:0]   password, password_n;
    logic [CNT_W-1:0]   cnt_n;
    logic [REM_W-1:0]   remain_n;
    logic [1:0]         err_n;
    logic               match_q, match_n;

    logic is_digit, is_enter, is_clear, is_set;
    logic buf_full, timer_last;

    assign is_digit   = key_valid && (key_code <= 4'd9);
    assign is_enter   = key_valid && (key_code == 4'hA);
    assign is_clear   = key_valid && (key_code == 4'hB);
    assign is_set     = key_valid && (key_code == 4'hC);
    assign buf_full   = (digit_cnt == CNT_W'(6));
    assign timer_last = tick && (remain == REM_W'(1));

    // Next-state and next-register values
    always_comb begin
        state_n    = state;
        entry_n    = entry;
        password_n = password;
        cnt_n      = digit_cnt;
        remain_n   = remain;
        err_n      = err_count;
        match_n    = match_q;

        case (state)
            IDLE: begin
                if (is_digit && !buf_full) begin
                    entry_n = {entry[PWD_W-5:0], key_code};
                    cnt_n   = digit_cnt + CNT_W'(1);
                end else if (is_clear) begin
                    entry_n = '0;
                    cnt_n   = '0;
                end else if (is_enter && buf_full) begin
                    state_n = JUDGE;
                    match_n = (entry == password);
                end
            end
            JUDGE: begin
                entry_n = '0;
                cnt_n   = '0;
                if (match_q) begin
                    err_n    = 2'd0;
                    state_n  = OPEN;
                    remain_n = REM_W'(UNLOCK_SECS);
                end else if (err_count < 2'd2) begin
                    err_n   = err_count + 2'd1;
                    state_n = IDLE;
                end else begin
                    err_n    = 2'd3;
                    state_n  = LOCKOUT;
                    remain_n = REM_W'(LOCKOUT_SECS);
                end
            end
            OPEN: begin
                // Expiry wins over any key in the same cycle
                if (timer_last) begin
                    state_n  = IDLE;
                    remain_n = '0;
                end else begin
                    if (tick) remain_n = remain - REM_W'(1);
                    if (is_enter) begin
                        state_n  = IDLE;
                        remain_n = '0;
                    end else if (is_set) begin
                        state_n = SETPWD;
                    end
                end
            end
            SETPWD: begin
                if (is_digit && !buf_full) begin
                    entry_n = {entry[PWD_W-5:0], key_code};
                    cnt_n   = digit_cnt + CNT_W'(1);
                end else if (is_clear) begin
                    entry_n  = '0;
                    cnt_n    = '0;
                    state_n  = OPEN;
                    remain_n = REM_W'(UNLOCK_SECS);
                end else if (is_enter && buf_full) begin
                    password_n = entry;
                    entry_n    = '0;
                    cnt_n      = '0;
                    state_n    = IDLE;
                    remain_n   = '0;
                end
            end
            LOCKOUT: begin
                if (timer_last) begin
                    state_n  = IDLE;
                    err_n    = 2'd0;
                    remain_n = '0;
                end else if (tick) begin
                    remain_n = remain - REM_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            entry     <= '0;
            password  <= DEFAULT_PWD;
            digit_cnt <= '0;
            remain    <= '0;
            err_count <= '0;
            match_q   <= 1'b0;
            unlocked  <= 1'b0;
            alarm     <= 1'b0;
            judge     <= 1'b0;
            pass_ok   <= 1'b0;
        end else begin
            state     <= state_n;
            entry     <= entry_n;
            password  <= password_n;
            digit_cnt <= cnt_n;
            remain    <= remain_n;
            err_count <= err_n;
            match_q   <= match_n;
            unlocked  <= (state_n == OPEN) || (state_n == SETPWD);
            alarm     <= (state_n == LOCKOUT);
            judge     <= (state_n == JUDGE);
            pass_ok   <= (state_n == JUDGE) && match_n;
        end
    end

endmodule
